// File: rtl/pipeline_hazard_ctrl.sv
// RAW hazard controller for the 4-stage integer pipeline: EX/WB destination tags, stall/bubble, drain FSM, stall counter.
// Optional operand forwarding from the WB slot is enabled with the PIPELINE_HAZARD_FWD_EN macro.
module pipeline_hazard_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs1_addr_i,
    input  logic              id_rs1_used_i,
    input  logic [ADDR_W-1:0] id_rs2_addr_i,
    input  logic              id_rs2_used_i,
    input  logic [ADDR_W-1:0] id_rd_addr_i,
    input  logic              id_rd_we_i,
    input  logic              drain_req_i,
    input  logic              stall_cnt_clr_i,
    output logic              issue_o,
    output logic              stall_o,
    output logic              id_bubble_o,
    output logic              drained_o,
    output logic [1:0]        inflight_o,
    output logic [CNT_W-1:0]  stall_cnt_o
`ifdef PIPELINE_HAZARD_FWD_EN
    ,
    output logic              fwd_rs1_o,
    output logic              fwd_rs2_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ex_v;
    logic                r_wb_v;
    logic [ADDR_W-1:0]   r_ex_rd;
    logic [ADDR_W-1:0]   r_wb_rd;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_rs1_chk;
    logic                w_rs2_chk;
    logic                w_rs1_ex;
    logic                w_rs1_wb;
    logic                w_rs2_ex;
    logic                w_rs2_wb;
    logic                w_hazard;
    logic                w_idle;
    logic                w_issue;
    logic                w_tags_empty;
    logic                w_ex_v_nxt;

    // Per-source slot matches; x0 and unused sources never participate
    assign w_rs1_chk = id_rs1_used_i & (id_rs1_addr_i != '0);
    assign w_rs2_chk = id_rs2_used_i & (id_rs2_addr_i != '0);
    assign w_rs1_ex  = w_rs1_chk & r_ex_v & (r_ex_rd == id_rs1_addr_i);
    assign w_rs1_wb  = w_rs1_chk & r_wb_v & (r_wb_rd == id_rs1_addr_i);
    assign w_rs2_ex  = w_rs2_chk & r_ex_v & (r_ex_rd == id_rs2_addr_i);
    assign w_rs2_wb  = w_rs2_chk & r_wb_v & (r_wb_rd == id_rs2_addr_i);

`ifdef PIPELINE_HAZARD_FWD_EN
    // WB data is forwarded, so only a producer still in EX forces a stall
    assign w_hazard  = w_rs1_ex | w_rs2_ex;
    assign fwd_rs1_o = w_rs1_wb & ~w_rs1_ex;
    assign fwd_rs2_o = w_rs2_wb & ~w_rs2_ex;
`else
    assign w_hazard  = w_rs1_ex | w_rs1_wb | w_rs2_ex | w_rs2_wb;
`endif

    assign w_idle       = (r_state == ST_IDLE);
    assign w_issue      = id_valid_i & ~w_hazard & w_idle;
    assign w_tags_empty = ~r_ex_v & ~r_wb_v;
    assign w_ex_v_nxt   = w_issue & id_rd_we_i & (id_rd_addr_i != '0);

    assign issue_o     = w_issue;
    assign stall_o     = id_valid_i & ~w_issue;
    assign id_bubble_o = ~w_issue;
    assign drained_o   = (r_state == ST_DRAINED);
    assign inflight_o  = 2'(r_ex_v) + 2'(r_wb_v);
    assign stall_cnt_o = r_stall_cnt;

    // Destination tag pipeline: decode -> EX -> WB -> retired
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_v  <= 1'b0;
            r_wb_v  <= 1'b0;
            r_ex_rd <= '0;
            r_wb_rd <= '0;
        end else begin
            r_ex_v  <= w_ex_v_nxt;
            r_ex_rd <= id_rd_addr_i;
            r_wb_v  <= r_ex_v;
            r_wb_rd <= r_ex_rd;
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain FSM next state; an empty pipeline completes the drain
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (drain_req_i) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_tags_empty) begin
                    w_state_nxt = ST_DRAINED;
                end else if (!drain_req_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAINED: begin
                if (!drain_req_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Saturating hazard-stall counter; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall_cnt_clr_i) begin
            r_stall_cnt <= '0;
        end else if (w_idle && id_valid_i && w_hazard && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against a write-history model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 4;
    localparam int          CMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              id_valid_i;
    logic [ADDR_W-1:0] id_rs1_addr_i;
    logic              id_rs1_used_i;
    logic [ADDR_W-1:0] id_rs2_addr_i;
    logic              id_rs2_used_i;
    logic [ADDR_W-1:0] id_rd_addr_i;
    logic              id_rd_we_i;
    logic              drain_req_i;
    logic              stall_cnt_clr_i;
    logic              issue_o;
    logic              stall_o;
    logic              id_bubble_o;
    logic              drained_o;
    logic [1:0]        inflight_o;
    logic [CNT_W-1:0]  stall_cnt_o;
`ifdef PIPELINE_HAZARD_FWD_EN
    logic              fwd_rs1_o;
    logic              fwd_rs2_o;
    localparam int     FWD = 1;
`else
    localparam int     FWD = 0;
`endif

    pipeline_hazard_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid_i      (id_valid_i),
        .id_rs1_addr_i   (id_rs1_addr_i),
        .id_rs1_used_i   (id_rs1_used_i),
        .id_rs2_addr_i   (id_rs2_addr_i),
        .id_rs2_used_i   (id_rs2_used_i),
        .id_rd_addr_i    (id_rd_addr_i),
        .id_rd_we_i      (id_rd_we_i),
        .drain_req_i     (drain_req_i),
        .stall_cnt_clr_i (stall_cnt_clr_i),
        .issue_o         (issue_o),
        .stall_o         (stall_o),
        .id_bubble_o     (id_bubble_o),
        .drained_o       (drained_o),
        .inflight_o      (inflight_o),
        .stall_cnt_o     (stall_cnt_o)
`ifdef PIPELINE_HAZARD_FWD_EN
        ,
        .fwd_rs1_o       (fwd_rs1_o),
        .fwd_rs2_o       (fwd_rs2_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: list of issued register writes stamped with their issue cycle
    typedef struct {
        longint c;
        int     rd;
    } wr_t;

    wr_t    q[$];
    longint cyc;
    int     mst;    // 0 running, 1 draining, 2 drained
    int     mcnt;
    int     checks;
    int     errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Youngest age (cycles since issue) of an in-flight write to reg a; 99 if none
    function automatic int min_age(input int a);
        int m;
        m = 99;
        foreach (q[i]) begin
            if (q[i].rd == a && int'(cyc - q[i].c) < m) m = int'(cyc - q[i].c);
        end
        return m;
    endfunction

    function automatic bit src_stall(input bit used, input int a);
        int age;
        age = min_age(a);
        if (!used || a == 0) return 1'b0;
        return (FWD != 0) ? (age == 1) : (age <= 2);
    endfunction

    function automatic bit src_fwd(input bit used, input int a);
        return used && a != 0 && FWD != 0 && min_age(a) == 2;
    endfunction

    task automatic model_reset();
        q.delete();
        mst  = 0;
        mcnt = 0;
    endtask

    // One cycle: drive, check all outputs against the model, then advance model and clock
    task automatic step(input bit v, input int a1, input bit u1, input int a2, input bit u2,
                        input int rd, input bit we, input bit dr, input bit clr, output bit issued);
        wr_t nq[$];
        bit  hz;
        bit  iss;
        id_valid_i      = v;
        id_rs1_addr_i   = ADDR_W'(a1);
        id_rs1_used_i   = u1;
        id_rs2_addr_i   = ADDR_W'(a2);
        id_rs2_used_i   = u2;
        id_rd_addr_i    = ADDR_W'(rd);
        id_rd_we_i      = we;
        drain_req_i     = dr;
        stall_cnt_clr_i = clr;
        #2;
        foreach (q[i]) if (cyc - q[i].c <= 2) nq.push_back(q[i]);
        q   = nq;
        hz  = src_stall(u1, a1) | src_stall(u2, a2);
        iss = v && !hz && mst == 0;
        chk("issue",    32'(issue_o),     32'(iss));
        chk("stall",    32'(stall_o),     32'(v && !iss));
        chk("bubble",   32'(id_bubble_o), 32'(!iss));
        chk("drained",  32'(drained_o),   32'(mst == 2));
        chk("inflight", 32'(inflight_o),  32'(q.size()));
        chk("stallcnt", 32'(stall_cnt_o), 32'(mcnt));
`ifdef PIPELINE_HAZARD_FWD_EN
        chk("fwd_rs1",  32'(fwd_rs1_o),   32'(src_fwd(u1, a1)));
        chk("fwd_rs2",  32'(fwd_rs2_o),   32'(src_fwd(u2, a2)));
`endif
        if (clr) mcnt = 0;
        else if (mst == 0 && v && hz && mcnt < CMAX) mcnt++;
        case (mst)
            0: if (dr) mst = 1;
            1: if (q.size() == 0) mst = 2; else if (!dr) mst = 0;
            default: if (!dr) mst = 0;
        endcase
        if (iss && we && rd != 0) q.push_back('{c: cyc, rd: rd});
        issued = iss;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present one instruction, holding it while stalled; returns stall cycles
    task automatic issue(input int a1, input bit u1, input int a2, input bit u2,
                         input int rd, input bit we, output int stalls);
        bit iss;
        bit done;
        stalls = 0;
        done   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!done) begin
                step(1'b1, a1, u1, a2, u2, rd, we, 1'b0, 1'b0, iss);
                if (iss) done = 1'b1;
                else stalls++;
            end
        end
        if (!done) chk("issue_timeout", 32'(done), 32'(1));
    endtask

    task automatic idle(input bit dr, input bit clr);
        bit iss;
        step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, dr, clr, iss);
    endtask

    initial begin
        int s;
        int tot;
        bit iss;
        checks = 0;
        errors = 0;
        cyc    = 0;
        model_reset();
        rst_n = 1'b0;
        id_valid_i = 1'b0; id_rs1_addr_i = '0; id_rs1_used_i = 1'b0;
        id_rs2_addr_i = '0; id_rs2_used_i = 1'b0; id_rd_addr_i = '0;
        id_rd_we_i = 1'b0; drain_req_i = 1'b0; stall_cnt_clr_i = 1'b0;
        #2;
        chk("rst_issue",    32'(issue_o),     32'(0));
        chk("rst_stall",    32'(stall_o),     32'(0));
        chk("rst_bubble",   32'(id_bubble_o), 32'(1));
        chk("rst_drained",  32'(drained_o),   32'(0));
        chk("rst_inflight", 32'(inflight_o),  32'(0));
        chk("rst_cnt",      32'(stall_cnt_o), 32'(0));
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Hazard-free sequence
        tot = 0;
        issue(0, 1'b1, 0, 1'b0, 1, 1'b1, s); tot += s;
        issue(3, 1'b1, 0, 1'b0, 2, 1'b1, s); tot += s;
        issue(4, 1'b1, 0, 1'b1, 3, 1'b1, s); tot += s;
        issue(0, 1'b1, 8, 1'b0, 4, 1'b1, s); tot += s;
        chk("nohaz_stalls", 32'(tot), 32'(0));
        chk("nohaz_cnt", 32'(stall_cnt_o), 32'(0));

        // Directly dependent pair
        issue(0, 1'b1, 0, 1'b0, 5, 1'b1, s);
        issue(5, 1'b1, 0, 1'b0, 6, 1'b1, s);
        chk("dep_stalls", 32'(s), 32'(FWD != 0 ? 1 : 2));
        chk("dep_cnt", 32'(stall_cnt_o), 32'(FWD != 0 ? 1 : 2));

        // One apart, then x0 writes/reads, then back-to-back writes to x7
        issue(0, 1'b1, 0, 1'b0, 10, 1'b1, s);
        issue(0, 1'b1, 0, 1'b0, 11, 1'b1, s);
        issue(0, 1'b1, 10, 1'b1, 12, 1'b1, s);
        chk("gap1_stalls", 32'(s), 32'(FWD != 0 ? 0 : 1));
        issue(0, 1'b1, 0, 1'b0, 0, 1'b1, s);
        issue(0, 1'b1, 0, 1'b1, 13, 1'b1, s);
        chk("x0_stalls", 32'(s), 32'(0));
        issue(0, 1'b1, 0, 1'b0, 7, 1'b1, s);
        issue(0, 1'b1, 0, 1'b0, 7, 1'b1, s);
        issue(7, 1'b1, 0, 1'b0, 14, 1'b1, s);
        chk("x7_stalls", 32'(s), 32'(FWD != 0 ? 1 : 2));

        // Drain with two instructions in flight, then resume
        issue(0, 1'b1, 0, 1'b0, 1, 1'b1, s);
        issue(0, 1'b1, 0, 1'b0, 2, 1'b1, s);
        chk("drain_start_inflight", 32'(inflight_o), 32'(2));
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        chk("drained_set", 32'(drained_o), 32'(1));
        step(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b1, 1'b0, iss);
        chk("drained_no_issue", 32'(iss), 32'(0));
        idle(1'b0, 1'b0);
        step(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0, 1'b0, iss);
        chk("resume_issue", 32'(iss), 32'(1));

        // Async reset during DRAIN with tags valid
        issue(0, 1'b1, 0, 1'b0, 8, 1'b1, s);
        issue(0, 1'b1, 0, 1'b0, 9, 1'b1, s);
        idle(1'b1, 1'b0);
        chk("pre_rst_inflight", 32'(inflight_o), 32'(1));
        id_valid_i = 1'b0; drain_req_i = 1'b0; id_rd_we_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inflight", 32'(inflight_o),  32'(0));
        chk("mid_rst_drained",  32'(drained_o),   32'(0));
        chk("mid_rst_cnt",      32'(stall_cnt_o), 32'(0));
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        issue(0, 1'b1, 0, 1'b0, 9, 1'b1, s);
        chk("post_rst_stalls", 32'(s), 32'(0));

        // Saturation, then clear together with a stall
        for (int i = 0; i < 19; i++) begin
            issue(0, 1'b1, 0, 1'b0, 5, 1'b1, s);
            issue(5, 1'b1, 0, 1'b0, 9, 1'b1, s);
        end
        chk("sat_cnt", 32'(stall_cnt_o), 32'(CMAX));
        issue(0, 1'b1, 0, 1'b0, 5, 1'b1, s);
        step(1'b1, 5, 1'b1, 0, 1'b0, 9, 1'b1, 1'b0, 1'b1, iss);
        chk("clr_with_stall_stalled", 32'(iss), 32'(0));
        chk("clr_with_stall_cnt", 32'(stall_cnt_o), 32'(0));

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, int'($urandom % 8), 1'($urandom), int'($urandom % 8), 1'($urandom),
                 int'($urandom % 8), 1'($urandom), 1'b0, ($urandom % 32) == 0, iss);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 4-stage fetch/decode/execute/writeback integer pipeline.
- Tracks the destination registers of in-flight instructions in a two-entry tag pipeline (EX and WB slots) and detects read-after-write hazards against the instruction in decode.
- On a hazard it holds PC and the fetch register, and injects a bubble into the decode register.
- Also provides a drain/halt sequence for debug, and a saturating hazard-stall counter.

Parameters:
- ADDR_W, 5, register address width; 32 architectural registers; x0 is never a hazard source.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid_i  input  1  decode stage holds a valid instruction.
- id_rs1_addr_i  input  ADDR_W  source register 1 of the decode instruction.
- id_rs1_used_i  input  1  instruction reads rs1.
- id_rs2_addr_i  input  ADDR_W  source register 2.
- id_rs2_used_i  input  1  instruction reads rs2; tied 0 for immediate-only ops.
- id_rd_addr_i  input  ADDR_W  destination register.
- id_rd_we_i  input  1  instruction writes rd.
- drain_req_i  input  1  request to stop issue and empty the pipeline.
- stall_cnt_clr_i  input  1  synchronous clear of the stall counter.
- issue_o  output  1  decode instruction advances into the decode register this cycle.
- stall_o  output  1  hold PC and fetch register this cycle.
- id_bubble_o  output  1  force the decode register write-enable and valid to 0 this cycle.
- drained_o  output  1  pipeline empty and halted (registered).
- inflight_o  output  2  count of valid tags (EX + WB), 0..2.
- stall_cnt_o  output  CNT_W  hazard stall cycles, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - EX and WB tags invalid; FSM in IDLE; stall_cnt_o=0; drained_o=0.
  - Combinational outputs settle to issue_o=0, stall_o=0, id_bubble_o=1 with id_valid_i=0.
- Register file timing is fixed: writes on the rising edge ending the WB cycle; reads are combinational with no write-through.
- Source match, per source s in {rs1, rs2}:
  - match_s = used_s & (addr_s != 0) & ((ex_v & ex_rd == addr_s) | (wb_v & wb_rd == addr_s)).
  - hazard = match_rs1 | match_rs2.
- Issue and stall logic:
  - issue_o = id_valid_i & ~hazard & (state == IDLE).
  - stall_o = id_valid_i & ~issue_o.
  - id_bubble_o = ~issue_o.
- Tag pipeline, every edge:
  - ex tag <= {issue_o & id_rd_we_i & (id_rd_addr_i != 0), id_rd_addr_i}.
  - wb tag <= ex tag.
  - No other source modifies the tags.
- Latency without forwarding: a dependent instruction directly behind its producer stalls exactly 2 cycles; one instruction apart, it stalls 1 cycle; two or more apart, it stalls 0 cycles.
- Back-to-back writes to the same rd: both tags are tracked independently. The hazard persists until neither slot matches.
- A write to x0 never creates a tag. Reading x0 never stalls.
- Drain FSM:
  - IDLE -> DRAIN when drain_req_i=1.
  - DRAIN -> DRAINED at the first edge where both tags are invalid (evaluated on current tags).
  - DRAIN -> IDLE if drain_req_i drops before empty.
  - DRAINED -> IDLE when drain_req_i=0.
  - drained_o=1 only in DRAINED.
  - No issue occurs in DRAIN or DRAINED, so stall_o follows id_valid_i.
- Stall counter:
  - Increments when state == IDLE & id_valid_i & hazard.
  - Holds at all-ones (saturates).
  - stall_cnt_clr_i has priority over increment: the counter reads 0 the next cycle even if a stall occurs in that cycle.
  - Drain cycles are not counted.
- inflight_o = ex_v + wb_v, combinational from the registered tags.
- Reset asserted mid-operation: all tags drop immediately; in-flight writes are no longer tracked.

Optional Feature:
- Macro: PIPELINE_HAZARD_FWD_EN.
- When defined:
  - Adds outputs fwd_rs1_o and fwd_rs2_o, each 1 bit. fwd_s = used_s & (addr_s != 0) & wb_v & (wb_rd == addr_s) & ~(ex_v & ex_rd == addr_s).
  - The datapath muxes writeback ALU data onto operand s when fwd_s is asserted.
  - The WB-slot match is then removed from hazard; only an EX-slot match stalls.
  - Directly dependent instruction stalls 1 cycle; one instruction apart stalls 0.
  - If both slots match the same source, the EX match governs: stall, no forward.
- When not defined: the ports are absent and the 2-cycle stall rules above apply.

Test Plan:
- Hazard-free sequence: issue addi x1, then addi x2, x3, x4 reading only x0 or unwritten regs -> issue_o=1 every cycle, stall_o never asserted, stall_cnt_o=0.
- addi x5, x0, 7 followed immediately by addi x6, x5, 1 -> stall_o high 2 cycles, one bubble per stall cycle, x6 issues on the 3rd cycle, stall_cnt_o=2; with PIPELINE_HAZARD_FWD_EN: 1 stall, fwd_rs1_o=1 in the issue cycle.
- Writes to x0 followed by a read of x0 -> no stall. Two writes to x7 back-to-back, then a read of x7 -> stall until both tags have cleared.
- drain_req_i=1 with 2 instructions in flight -> inflight_o goes 2, 1, 0; drained_o=1 one cycle after the tags empty; deassert drain_req_i -> IDLE, issue resumes next cycle.
- Force 2^CNT_W+3 hazard cycles (CNT_W=4 override) -> stall_cnt_o holds at 15. Assert stall_cnt_clr_i together with a stall -> 0 the next cycle.
- Assert rst_n=0 asynchronously during DRAIN with tags valid -> inflight_o=0, drained_o=0, stall_cnt_o=0 immediately; after release, FSM is in IDLE.
